// File: rtl/fp_norm_round.sv
`default_nettype none
// ============================================================================
//  Module      : fp_norm_round
//  Description : Normalize, round and pack a wide pre-normalized FP result
//                into IEEE-754 binary32. Normalization is iterative, with up
//                to SHIFT_PER_CYCLE bit positions per cycle. Four rounding
//                modes are supported, with overflow, underflow and inexact
//                flags. Valid/ready handshakes are used on both sides, and
//                only one operation is in flight at a time.
//  Options     : define FP_FTZ_EN to flush subnormal results to signed zero.
//                By default, gradual underflow is used.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_norm_round #(
    parameter int C_EXP           = 8,
    parameter int C_MANT          = 23,
    parameter int C_EXP_PRENORM   = 10,
    parameter int C_MANT_PRENORM  = 48,
    parameter int SHIFT_PER_CYCLE = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic                      sign_i,
    input  logic [C_EXP_PRENORM-1:0]  exp_i,
    input  logic [C_MANT_PRENORM-1:0] mant_i,
    input  logic [2:0]                rm_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [C_EXP+C_MANT:0]     result_o,
    output logic                      of_o,
    output logic                      uf_o,
    output logic                      nx_o
);

    // Internal exponent is one bit wider than the input so it never wraps.
    localparam int c_ew  = C_EXP_PRENORM + 1;
    localparam int c_hid = C_MANT_PRENORM - 2;     // hidden-one position
    localparam int c_cry = C_MANT_PRENORM - 1;     // carry-out position
    localparam int c_grd = c_hid - 1 - C_MANT;     // guard bit position
    localparam int c_rw  = C_EXP + C_MANT + 1;

    localparam logic signed [c_ew-1:0] c_exp_one = c_ew'(1);
    localparam logic signed [c_ew-1:0] c_exp_inf = c_ew'((1 << C_EXP) - 1);
    localparam logic signed [c_ew-1:0] c_spc     = c_ew'(SHIFT_PER_CYCLE);
    localparam logic signed [c_ew-1:0] c_lz_max  = c_ew'(c_hid);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_norm  = 2'd1;
    localparam logic [1:0] c_st_round = 2'd2;
    localparam logic [1:0] c_st_out   = 2'd3;

    logic [1:0]                state_q,  state_d;
    logic                      sign_q,   sign_d;
    logic signed [c_ew-1:0]    exp_q,    exp_d;
    logic [C_MANT_PRENORM-1:0] mant_q,   mant_d;
    logic [2:0]                rm_q,     rm_d;
    logic                      sticky_q, sticky_d;
    logic [c_rw-1:0]           result_q, result_d;
    logic                      of_q,     of_d;
    logic                      uf_q,     uf_d;
    logic                      nx_q,     nx_d;

    // Normalization helpers
    logic signed [c_ew-1:0]    w_rsh;
    logic [C_MANT_PRENORM-1:0] w_rmask;
    logic signed [c_ew-1:0]    w_lz;
    logic signed [c_ew-1:0]    w_lsh;
    logic signed [c_ew-1:0]    w_exp_m1;

    // Rounding helpers
    logic [C_MANT-1:0]         w_frac;
    logic                      w_guard;
    logic                      w_stk;
    logic                      w_inc;
    logic [C_MANT+1:0]         w_sum;
    logic                      w_hid_r;
    logic signed [c_ew-1:0]    w_exp_r;
    logic [C_EXP-1:0]          w_expf;
    logic                      w_ovf;
    logic                      w_inf_sel;
    logic [c_rw-1:0]           w_res;
    logic                      w_of;
    logic                      w_uf;
    logic                      w_nx;

    assign ready_o  = (state_q == c_st_idle);
    assign valid_o  = (state_q == c_st_out);
    assign result_o = result_q;
    assign of_o     = of_q;
    assign uf_o     = uf_q;
    assign nx_o     = nx_q;

    // Shift amounts for one normalization step (right for tiny exponents,
    // left to bring the leading one up to the hidden position).
    always_comb begin
        // Right shift: min(1 - exp, SHIFT_PER_CYCLE)
        w_rsh = c_exp_one - exp_q;
        if (w_rsh > c_spc) begin
            w_rsh = c_spc;
        end
        w_rmask = ~({C_MANT_PRENORM{1'b1}} << w_rsh);

        // Distance from the leading one (below the hidden bit) up to the hidden bit
        w_lz = c_lz_max;
        for (int i = 0; i < c_hid; i++) begin
            if (mant_q[i]) begin
                w_lz = c_ew'(c_hid - i);
            end
        end

        // Left shift: min(lz, SHIFT_PER_CYCLE, exp - 1)
        w_exp_m1 = exp_q - c_exp_one;
        w_lsh    = w_lz;
        if (w_lsh > c_spc) begin
            w_lsh = c_spc;
        end
        if (w_lsh > w_exp_m1) begin
            w_lsh = w_exp_m1;
        end
    end

    // Rounding, exponent packing and exception handling of the normalized value
    always_comb begin
        w_frac  = mant_q[c_hid-1 -: C_MANT];
        w_guard = mant_q[c_grd];
        w_stk   = (|mant_q[c_grd-1:0]) | sticky_q;

        case (rm_q)
            3'd0:    w_inc = w_guard & (w_stk | w_frac[0]);
            3'd2:    w_inc = sign_q & (w_guard | w_stk);
            3'd3:    w_inc = ~sign_q & (w_guard | w_stk);
            default: w_inc = 1'b0;
        endcase

        // The top bit catches a carry out of an all-ones significand; a
        // subnormal rounding up into the hidden bit becomes normal with exp 1.
        w_sum   = {1'b0, mant_q[c_hid], w_frac} + {{(C_MANT+1){1'b0}}, w_inc};
        w_hid_r = w_sum[C_MANT+1] | w_sum[C_MANT];
        w_exp_r = w_sum[C_MANT+1] ? (exp_q + c_exp_one) : exp_q;
        w_expf  = w_hid_r ? w_exp_r[C_EXP-1:0] : {C_EXP{1'b0}};
        w_ovf   = w_hid_r && (w_exp_r >= c_exp_inf);

        // Saturate to infinity only when the rounding direction points outward
        w_inf_sel = (rm_q == 3'd0) || ((rm_q == 3'd3) && !sign_q) ||
                    ((rm_q == 3'd2) && sign_q);

        w_res = {sign_q, w_expf, w_sum[C_MANT-1:0]};
        w_of  = 1'b0;
        w_nx  = w_guard | w_stk;
        w_uf  = (w_expf == {C_EXP{1'b0}}) & (w_guard | w_stk);

        if (w_ovf) begin
            w_of = 1'b1;
            w_nx = 1'b1;
            w_uf = 1'b0;
            if (w_inf_sel) begin
                w_res = {sign_q, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
            end else begin
                w_res = {sign_q, {(C_EXP-1){1'b1}}, 1'b0, {C_MANT{1'b1}}};
            end
        end
`ifdef FP_FTZ_EN
        // Flush any subnormal result to a signed zero
        if (!w_ovf && (w_expf == {C_EXP{1'b0}}) && (w_sum[C_MANT-1:0] != {C_MANT{1'b0}})) begin
            w_res = {sign_q, {(C_EXP+C_MANT){1'b0}}};
            w_uf  = 1'b1;
            w_nx  = 1'b1;
        end
`endif
    end

    // Control FSM and datapath next-state selection
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        rm_d     = rm_q;
        sticky_d = sticky_q;
        result_d = result_q;
        of_d     = of_q;
        uf_d     = uf_q;
        nx_d     = nx_q;

        case (state_q)
            c_st_idle: begin
                if (valid_i) begin
                    sign_d   = sign_i;
                    exp_d    = {exp_i[C_EXP_PRENORM-1], exp_i};
                    mant_d   = mant_i;
                    rm_d     = rm_i;
                    sticky_d = 1'b0;
                    if (mant_i == {C_MANT_PRENORM{1'b0}}) begin
                        // Exact zero bypasses normalization and rounding
                        result_d = {sign_i, {(C_EXP+C_MANT){1'b0}}};
                        of_d     = 1'b0;
                        uf_d     = 1'b0;
                        nx_d     = 1'b0;
                        state_d  = c_st_out;
                    end else begin
                        state_d  = c_st_norm;
                    end
                end
            end

            c_st_norm: begin
                if (mant_q[c_cry]) begin
                    mant_d   = mant_q >> 1;
                    exp_d    = exp_q + c_exp_one;
                    sticky_d = sticky_q | mant_q[0];
                    state_d  = c_st_round;
                end else if (exp_q < c_exp_one) begin
                    mant_d   = mant_q >> w_rsh;
                    exp_d    = exp_q + w_rsh;
                    sticky_d = sticky_q | (|(mant_q & w_rmask));
                end else if (mant_q[c_hid] || (exp_q == c_exp_one)) begin
                    state_d  = c_st_round;
                end else begin
                    mant_d   = mant_q << w_lsh;
                    exp_d    = exp_q - w_lsh;
                end
            end

            c_st_round: begin
                result_d = w_res;
                of_d     = w_of;
                uf_d     = w_uf;
                nx_d     = w_nx;
                state_d  = c_st_out;
            end

            default: begin
                if (ready_i) begin
                    state_d = c_st_idle;
                end
            end
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= c_st_idle;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            rm_q     <= 3'd0;
            sticky_q <= 1'b0;
            result_q <= '0;
            of_q     <= 1'b0;
            uf_q     <= 1'b0;
            nx_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            rm_q     <= rm_d;
            sticky_q <= sticky_d;
            result_q <= result_d;
            of_q     <= of_d;
            uf_q     <= uf_d;
            nx_q     <= nx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_norm_round.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_norm_round
//  Description : Self-checking bench for fp_norm_round. It runs directed
//                cases and randomized operands against an exact-arithmetic
//                IEEE-754 rounding reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_norm_round;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic        sign_i;
    logic [9:0]  exp_i;
    logic [47:0] mant_i;
    logic [2:0]  rm_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        of_o;
    logic        uf_o;
    logic        nx_o;

    int n_checks = 0;
    int n_errors = 0;

    fp_norm_round dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .sign_i   (sign_i),
        .exp_i    (exp_i),
        .mant_i   (mant_i),
        .rm_i     (rm_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .of_o     (of_o),
        .uf_o     (uf_o),
        .nx_o     (nx_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Exact reference: value = m * 2^(e - 173), rounded to binary32.
    task automatic ref_model(input logic s, input int e, input logic [47:0] m,
                             input logic [2:0] rm, output logic [31:0] res,
                             output logic of, output logic uf, output logic nx);
        int p, eb, ebx, d;
        longint unsigned q, mag;
        bit g, st, inc;
        of = 1'b0; uf = 1'b0; nx = 1'b0;
        if (m == 48'd0) begin
            res = {s, 31'd0};
            return;
        end
        p = 0;
        for (int i = 0; i < 48; i++) if (m[i]) p = i;
        eb = e + p - 46;                      // biased exponent if normal
        d  = (eb >= 1) ? (p - 23) : (24 - e); // bits dropped below the LSB
        if (d <= 0) begin
            q = 64'(m) << (-d); g = 0; st = 0;
        end else if (d > 48) begin
            q = 0; g = 0; st = 1;
        end else begin
            q  = 64'(m) >> d;
            g  = m[d-1];
            st = (64'(m) & ((64'd1 << (d-1)) - 64'd1)) != 64'd0;
        end
        case (rm)
            3'd0:    inc = g & (st | q[0]);
            3'd2:    inc = s & (g | st);
            3'd3:    inc = !s & (g | st);
            default: inc = 0;
        endcase
        q   = q + 64'(inc);
        ebx = (eb >= 1) ? eb : 1;
        mag = (64'(ebx - 1) << 23) + q;
        if (mag >= 64'h7F80_0000) begin
            of = 1'b1; nx = 1'b1;
            if (rm == 3'd0 || (rm == 3'd3 && !s) || (rm == 3'd2 && s)) res = {s, 31'h7F80_0000};
            else res = {s, 31'h7F7F_FFFF};
        end else begin
            nx  = g | st;
            uf  = (mag < 64'h0080_0000) & nx;
            res = {s, mag[30:0]};
`ifdef FP_FTZ_EN
            if (mag < 64'h0080_0000 && mag != 64'd0) begin
                res = {s, 31'd0}; uf = 1'b1; nx = 1'b1;
            end
`endif
        end
    endtask

    // Present one operand (caller is at #1 after a posedge, DUT idle) and
    // wait for valid_o; lat counts the accept edge as cycle 1.
    task automatic run_op(input logic s, input int e, input logic [47:0] m, input logic [2:0] rm,
                          output int lat, output bit ok);
        valid_i = 1'b1; sign_i = s; exp_i = 10'(e); mant_i = m; rm_i = rm;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 200) begin
            @(posedge clk_i); #1;
            lat++;
        end
        ok = valid_o;
    endtask

    task automatic recover();
        rst_ni = 1'b0; #2;
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    // Full operation with result/flag checks; exp_lat < 0 skips the latency check.
    task automatic check_op(input string tag, input logic s, input int e, input logic [47:0] m,
                            input logic [2:0] rm, input logic [31:0] er, input logic eo,
                            input logic eu, input logic en, input int exp_lat);
        int lat; bit ok;
        run_op(s, e, m, rm, lat, ok);
        if (!ok) begin
            check({tag, ".timeout"}, 64'(ok), 64'd1);
            recover();
            return;
        end
        check({tag, ".res"}, 64'(result_o), 64'(er));
        check({tag, ".of"},  64'(of_o), 64'(eo));
        check({tag, ".uf"},  64'(uf_o), 64'(eu));
        check({tag, ".nx"},  64'(nx_o), 64'(en));
        if (exp_lat >= 0) check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        if (ready_i) begin
            @(posedge clk_i); #1;
        end
    endtask

    logic [47:0] one46, one47, one30, one22, one20;

    initial begin
        logic [31:0] er; logic eo, eu, en;
        logic [47:0] m; int e; logic s; logic [2:0] rm;

        one46 = 48'd1 << 46; one47 = 48'd1 << 47; one30 = 48'd1 << 30;
        one22 = 48'd1 << 22; one20 = 48'd1 << 20;

        rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        sign_i = 1'b0; exp_i = '0; mant_i = '0; rm_i = 3'd0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset.ready", 64'(ready_o), 64'd1);
        check("reset.valid", 64'(valid_o), 64'd0);
        check("reset.result", 64'(result_o), 64'd0);
        check("reset.flags", 64'({of_o, uf_o, nx_o}), 64'd0);
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Directed cases
        check_op("pass",     0, 127, one46,         3'd0, 32'h3F80_0000, 0, 0, 0, 3);
        check_op("tie.rne",  0, 127, one46 | one22, 3'd0, 32'h3F80_0000, 0, 0, 1, 3);
        check_op("tie.rup",  0, 127, one46 | one22, 3'd3, 32'h3F80_0001, 0, 0, 1, 3);
        check_op("tie.rdn",  0, 127, one46 | one22, 3'd2, 32'h3F80_0000, 0, 0, 1, 3);
        check_op("carry",    0, 127, one47,         3'd0, 32'h4000_0000, 0, 0, 0, 3);
        check_op("lshift",   0, 127, one30,         3'd0, 32'h3780_0000, 0, 0, 0, 5);
        check_op("ovf.rtz",  0, 300, one46,         3'd1, 32'h7F7F_FFFF, 1, 0, 1, -1);
        check_op("ovf.rne",  0, 300, one46,         3'd0, 32'h7F80_0000, 1, 0, 1, -1);
        check_op("zero",     1, 50,  48'd0,         3'd0, 32'h8000_0000, 0, 0, 0, 1);
`ifdef FP_FTZ_EN
        check_op("subn",     0, -2,  one46,         3'd0, 32'h0000_0000, 0, 1, 1, -1);
`else
        check_op("subn",     0, -2,  one46,         3'd0, 32'h0010_0000, 0, 0, 0, -1);
`endif

        // Result held while downstream stalls; new operands ignored
        ready_i = 1'b0;
        check_op("hold", 0, 127, one46 | one22, 3'd3, 32'h3F80_0001, 0, 0, 1, 3);
        for (int k = 0; k < 10; k++) begin
            valid_i = 1'b1; sign_i = 1'b1; exp_i = 10'd5; mant_i = 48'h123; rm_i = 3'd1;
            @(posedge clk_i); #1;
            check("hold.res", 64'(result_o), 64'h3F80_0001);
            check("hold.valid", 64'(valid_o), 64'd1);
            check("hold.ready", 64'(ready_o), 64'd0);
        end
        valid_i = 1'b0; ready_i = 1'b1;
        @(posedge clk_i); #1;
        check("hold.rel.valid", 64'(valid_o), 64'd0);
        check("hold.rel.ready", 64'(ready_o), 64'd1);
        check_op("after.hold", 0, 127, one47, 3'd0, 32'h4000_0000, 0, 0, 0, 3);

        // Reset in the middle of normalization
        valid_i = 1'b1; sign_i = 1'b0; exp_i = 10'd127; mant_i = one20; rm_i = 3'd0;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        check("rst.busy", 64'(ready_o), 64'd0);
        rst_ni = 1'b0; #1;
        check("rst.ready", 64'(ready_o), 64'd1);
        check("rst.valid", 64'(valid_o), 64'd0);
        check("rst.result", 64'(result_o), 64'd0);
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check_op("after.rst", 1, 127, one46, 3'd0, 32'hBF80_0000, 0, 0, 0, 3);

        // Randomized operands against the reference
        for (int i = 0; i < 300; i++) begin
            m = {16'($urandom), $urandom};
            m = m >> $urandom_range(0, 47);
            if ($urandom_range(0, 19) == 0) m = '0;
            case ($urandom_range(0, 3))
                0:       e = int'($urandom_range(0, 40)) - 30;
                1:       e = int'($urandom_range(230, 290));
                2:       e = int'($urandom_range(0, 300)) - 250;
                default: e = int'($urandom_range(1, 254));
            endcase
            if (m[47] && e < 1) e = 1;
            s  = 1'($urandom);
            rm = 3'($urandom_range(0, 3));
            ref_model(s, e, m, rm, er, eo, eu, en);
            check_op($sformatf("rnd%0d", i), s, e, m, rm, er, eo, eu, en, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
